alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm controller that sits directly downstream of the watch/time-keeping stage.
//  Consumes the current BCD time (HH:MM) and the registered seconds count.
//  Compares them with the user alarm time and drives the audio enable for the sound stage.
//  Handles ringing timeout, snooze with 24 h wrap-around, and stop.
// PARAMETERS
//  RING_SEC    60  seconds an alarm rings before auto-stop (1..63)
//  SNOOZE_MIN  5   snooze length in minutes (1..59)
//  SYNC_STAGES 2   synchroniser depth for snooze_btn/stop_btn (>=2)
// PORTS
//  clk           in   1  system clock (100 MHz)
//  rstn          in   1  asynchronous reset, ACTIVE-HIGH (1 = reset)
//  hourdec_now   in   4  current hour tens, BCD 0..2
//  hourone_now   in   4  current hour units, BCD 0..9
//  mindec_now    in   4  current minute tens, BCD 0..5
//  minone_now    in   4  current minute units, BCD 0..9
//  cnt_sec       in   6  current seconds 0..59 (registered, from time stage)
//  hourdec_bud, hourone_bud, mindec_bud, minone_bud  in  4 each  alarm time, BCD
//  alarm_en      in   1  level; 0 disarms alarm and forces IDLE
//  snooze_btn    in   1  async button, active-high
//  stop_btn      in   1  async button, active-high
//  aud_en        out  1  1 while ringing; enables sound generator
//  snooze_act    out  1  1 while a snooze is pending
//  ring_sec      out  6  seconds elapsed in current ring
// BEHAVIOUR
//  Reset: state=IDLE; aud_en=0, snooze_act=0, ring_sec=0; sec_prev=0; sync chains=0.
//  sec_tick: 1-cycle pulse when cnt_sec != sec_prev (sec_prev updates every clk).
//  min_tick: sec_tick AND cnt_sec==0.
//  Buttons: SYNC_STAGES flops, then rising-edge detect -> 1-cycle snz_p / stp_p.
//  FSM (alarm_state_t): IDLE, RING, SNOOZE.
//   IDLE  -> RING   on min_tick & alarm_en & now==bud (all four digits).
//   RING  -> IDLE   on stp_p, or on sec_tick when ring_sec==RING_SEC-1.
//   RING  -> SNOOZE on snz_p (and no stp_p); latch snz_time = now + SNOOZE_MIN.
//   SNOOZE-> RING   on min_tick & now==snz_time.
//   SNOOZE-> IDLE   on stp_p.
//   any   -> IDLE   when alarm_en==0 (highest priority after reset).
//  Priority in RING on the same cycle: alarm_en=0 > stp_p > timeout > snz_p.
//  ring_sec: cleared on every entry to RING; +1 on each sec_tick in RING; saturates at 63.
//  aud_en = (state==RING), registered: rises 1 clk after the transition cycle.
//  snooze_act = (state==SNOOZE), registered.
//  Snooze add: minutes BCD + SNOOZE_MIN. Carry at 60 increments the hour.
//   Hour wraps 23 -> 00 (e.g. 23:58 + 5 = 00:03).
//  A snooze expiry and a bud match at the same minute produce a single RING entry.
//  Buttons are ignored in IDLE.
//  A match while already in RING does not restart ring_sec.
//  Reset asserted mid-ring clears aud_en asynchronously, in the same cycle.
//  Non-BCD input digits never match and cause no X propagation.
// STRUCTURE
//  alarm_pkg:
//   - typedef enum logic [1:0] alarm_state_t {IDLE, RING, SNOOZE}
//   - typedef struct packed bcd_time_t {hd, ho, md, mo} (4 bits each)
//   - localparams for max hour/minute digits
//  Sub-module bcd_time_add (combinational): bcd_time_t + minutes -> bcd_time_t,
//   24 h wrap; instantiated once for the snooze target.
//  Top holds the synchronisers, tick detection, FSM, ring counter and output regs.
// TESTING
//  1 Reset: rstn=1 for 3 clk -> aud_en=0, snooze_act=0, ring_sec=0; hold through a matching time.
//  2 Match: bud=07:30, alarm_en=1, now 07:29:59 -> 07:30:00 -> aud_en=1 within 2 clk.
//    Now already 07:30 with cnt_sec=17 -> no ring.
//  3 Timeout, RING_SEC=60: 60 sec_ticks in RING -> aud_en=0, state IDLE, no re-ring until next day.
//  4 Snooze wrap: ring at 23:58, pulse snooze_btn ->
//    snooze_act=1, aud_en=0; at 00:03:00 -> aud_en=1, ring_sec=0.
//  5 Simultaneous: stop_btn and snooze_btn rise on the same clk -> IDLE.
//    alarm_en dropped during SNOOZE -> IDLE, snooze_act=0.
//  6 Async reset mid-ring: assert rstn between clk edges -> aud_en=0 immediately;
//    release -> IDLE, no ring until next matching minute boundary.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg
//    Shared types and helpers for the alarm controller: FSM state encoding,
//    packed BCD HH:MM time and a digit-range check used for matching.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   typedef struct packed {
      logic [3:0] hd;   // hour tens
      logic [3:0] ho;   // hour units
      logic [3:0] md;   // minute tens
      logic [3:0] mo;   // minute units
   } bcd_time_t;

   localparam logic [3:0] MAX_HD       = 4'd2;   // hour tens 0..2
   localparam logic [3:0] MAX_HO       = 4'd9;   // hour units 0..9
   localparam logic [3:0] MAX_HO_LAST  = 4'd3;   // hour units limit when tens==2
   localparam logic [3:0] MAX_MD       = 4'd5;   // minute tens 0..5
   localparam logic [3:0] MAX_MO       = 4'd9;   // minute units 0..9

   // True only for a legal 00:00..23:59 BCD time; anything else must never match.
   function automatic logic bcd_time_valid(input bcd_time_t t);
      logic hour_ok;
      hour_ok = (t.hd < MAX_HD) ? (t.ho <= MAX_HO)
                                : ((t.hd == MAX_HD) && (t.ho <= MAX_HO_LAST));
      return hour_ok && (t.md <= MAX_MD) && (t.mo <= MAX_MO);
   endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_time_add.sv
// bcd_time_add
//    Combinational HH:MM + minutes in BCD with minute carry into the hour and
//    24 h wrap (23:58 + 5 -> 00:03). Out-of-range inputs give a defined,
//    X-free result that is never used for a match.
// Ports
//    t_i        in   bcd_time_t  base time
//    add_min_i  in   6           minutes to add (0..59)
//    sum_o      out  bcd_time_t  resulting time
module bcd_time_add
   import alarm_pkg::*;
(
   input  bcd_time_t  t_i,
   input  logic [5:0] add_min_i,
   output bcd_time_t  sum_o
);

   logic [7:0] min_total_s;
   logic [7:0] hour_total_s;
   logic [7:0] min_wrap_s;
   logic [7:0] hour_wrap_s;

   // Convert to binary, add, carry minutes into hours, wrap the day, convert back.
   always_comb begin
      min_total_s  = ({4'd0, t_i.md} * 8'd10) + {4'd0, t_i.mo} + {2'd0, add_min_i};
      hour_total_s = ({4'd0, t_i.hd} * 8'd10) + {4'd0, t_i.ho};
      if (min_total_s >= 8'd60) begin
         min_wrap_s   = min_total_s - 8'd60;
         hour_total_s = hour_total_s + 8'd1;
      end else begin
         min_wrap_s   = min_total_s;
      end
      if (hour_total_s >= 8'd24) begin
         hour_wrap_s = hour_total_s - 8'd24;
      end else begin
         hour_wrap_s = hour_total_s;
      end
      sum_o.hd = 4'(hour_wrap_s / 8'd10);
      sum_o.ho = 4'(hour_wrap_s % 8'd10);
      sum_o.md = 4'(min_wrap_s / 8'd10);
      sum_o.mo = 4'(min_wrap_s % 8'd10);
   end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
//    Alarm controller downstream of the time-keeping stage. Rings when the
//    current HH:MM reaches the alarm time at a minute boundary, times out after
//    RING_SEC seconds, supports snooze (with 24 h wrap) and stop.
// Ports
//    clk, rstn                 clock, asynchronous active-high reset
//    *_now, cnt_sec            current BCD time and seconds
//    *_bud                     alarm time, BCD
//    alarm_en                  level arm; 0 forces IDLE
//    snooze_btn, stop_btn      asynchronous buttons, active-high
//    aud_en, snooze_act        registered RING / SNOOZE indications
//    ring_sec                  seconds elapsed in the current ring
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SEC    = 60,
   parameter int SNOOZE_MIN  = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   input  logic [5:0] cnt_sec,
   input  logic [3:0] hourdec_bud,
   input  logic [3:0] hourone_bud,
   input  logic [3:0] mindec_bud,
   input  logic [3:0] minone_bud,
   input  logic       alarm_en,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       aud_en,
   output logic       snooze_act,
   output logic [5:0] ring_sec
);

   localparam logic [5:0] RING_LAST = 6'(RING_SEC - 1);
   localparam logic [5:0] RING_MAX  = 6'd63;

   bcd_time_t        now_s, bud_s, snz_add_s;
   bcd_time_t        snz_time_q, snz_time_d;
   alarm_state_t     state_q, state_d;
   logic [5:0]       ring_sec_q, ring_sec_d;
   logic [5:0]       sec_prev_q;
   logic [SYNC_STAGES-1:0] snz_sync_q, stp_sync_q;
   logic             snz_last_q, stp_last_q;
   logic             aud_en_q, snooze_act_q;
   logic             sec_tick_s, min_tick_s, snz_p_s, stp_p_s;
   logic             now_ok_s, bud_match_s, snz_match_s;

   assign now_s = {hourdec_now, hourone_now, mindec_now, minone_now};
   assign bud_s = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};

   bcd_time_add u_snz_add (
      .t_i       (now_s),
      .add_min_i (6'(SNOOZE_MIN)),
      .sum_o     (snz_add_s)
   );

   assign sec_tick_s  = (cnt_sec != sec_prev_q);
   assign min_tick_s  = sec_tick_s && (cnt_sec == 6'd0);
   assign snz_p_s     = snz_sync_q[SYNC_STAGES-1] && !snz_last_q;
   assign stp_p_s     = stp_sync_q[SYNC_STAGES-1] && !stp_last_q;
   // Requiring a valid "now" keeps garbage digits from ever matching.
   assign now_ok_s    = bcd_time_valid(now_s);
   assign bud_match_s = now_ok_s && (now_s == bud_s);
   assign snz_match_s = now_ok_s && (now_s == snz_time_q);

   // Next-state logic for the alarm FSM, ring counter and snooze target.
   always_comb begin
      state_d    = state_q;
      ring_sec_d = ring_sec_q;
      snz_time_d = snz_time_q;
      if (!alarm_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (min_tick_s && bud_match_s) begin
                  state_d    = RING;
                  ring_sec_d = 6'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            RING: begin
               // stop beats timeout beats snooze; a fresh match does not restart.
               if (stp_p_s) begin
                  state_d = IDLE;
               end else if (sec_tick_s && (ring_sec_q == RING_LAST)) begin
                  state_d = IDLE;
               end else if (snz_p_s) begin
                  state_d    = SNOOZE;
                  snz_time_d = snz_add_s;
               end else begin
                  state_d = RING;
               end
               if (sec_tick_s && (ring_sec_q != RING_MAX)) begin
                  ring_sec_d = ring_sec_q + 6'd1;
               end else begin
                  ring_sec_d = ring_sec_q;
               end
            end
            SNOOZE: begin
               // Snooze expiry and alarm match in the same minute collapse into one entry.
               if (stp_p_s) begin
                  state_d = IDLE;
               end else if (min_tick_s && (snz_match_s || bud_match_s)) begin
                  state_d    = RING;
                  ring_sec_d = 6'd0;
               end else begin
                  state_d = SNOOZE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, synchronisers, edge detectors, tick history and registered outputs.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q      <= IDLE;
         ring_sec_q   <= 6'd0;
         snz_time_q   <= '0;
         sec_prev_q   <= 6'd0;
         snz_sync_q   <= '0;
         stp_sync_q   <= '0;
         snz_last_q   <= 1'b0;
         stp_last_q   <= 1'b0;
         aud_en_q     <= 1'b0;
         snooze_act_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_sec_q   <= ring_sec_d;
         snz_time_q   <= snz_time_d;
         sec_prev_q   <= cnt_sec;
         snz_sync_q   <= {snz_sync_q[SYNC_STAGES-2:0], snooze_btn};
         stp_sync_q   <= {stp_sync_q[SYNC_STAGES-2:0], stop_btn};
         snz_last_q   <= snz_sync_q[SYNC_STAGES-1];
         stp_last_q   <= stp_sync_q[SYNC_STAGES-1];
         aud_en_q     <= (state_d == RING);
         snooze_act_q <= (state_d == SNOOZE);
      end
   end

   assign aud_en     = aud_en_q;
   assign snooze_act = snooze_act_q;
   assign ring_sec   = ring_sec_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl
//    Directed stimulus for alarm_ctrl with a minutes-of-day reference model
//    checked every clock, plus hand-computed expectations at key points.
module tb_alarm_ctrl;

   localparam int RING_SEC    = 60;
   localparam int SNOOZE_MIN  = 5;
   localparam int SYNC_STAGES = 2;
   localparam int CPS         = 3;   // clocks per simulated second

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
   logic [5:0] cnt_sec;
   logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
   logic       alarm_en, snooze_btn, stop_btn;
   logic       aud_en, snooze_act;
   logic [5:0] ring_sec;

   int total = 0;
   int bad   = 0;
   int sod   = 0;

   alarm_ctrl #(
      .RING_SEC    (RING_SEC),
      .SNOOZE_MIN  (SNOOZE_MIN),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .hourdec_now (hourdec_now),
      .hourone_now (hourone_now),
      .mindec_now  (mindec_now),
      .minone_now  (minone_now),
      .cnt_sec     (cnt_sec),
      .hourdec_bud (hourdec_bud),
      .hourone_bud (hourone_bud),
      .mindec_bud  (mindec_bud),
      .minone_bud  (minone_bud),
      .alarm_en    (alarm_en),
      .snooze_btn  (snooze_btn),
      .stop_btn    (stop_btn),
      .aud_en      (aud_en),
      .snooze_act  (snooze_act),
      .ring_sec    (ring_sec)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Minutes of day for a legal BCD time, -1 otherwise.
   function automatic int to_min(input logic [3:0] hd, input logic [3:0] ho,
                                 input logic [3:0] md, input logic [3:0] mo);
      int h;
      h = int'(hd) * 10 + int'(ho);
      if (hd > 4'd2 || ho > 4'd9 || md > 4'd5 || mo > 4'd9 || h > 23) return -1;
      return h * 60 + int'(md) * 10 + int'(mo);
   endfunction

   // ---------------- reference model ----------------
   int m_state = 0;             // 0 idle, 1 ringing, 2 snoozing
   int m_ring  = 0;
   int m_prev  = 0;
   int m_snz   = 0;
   bit h_snz[0:SYNC_STAGES];    // [0] = button at the previous edge, older further up
   bit h_stp[0:SYNC_STAGES];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rstn) begin
            m_state = 0; m_ring = 0; m_prev = 0;
            for (int i = 0; i <= SYNC_STAGES; i++) begin
               h_snz[i] = 1'b0; h_stp[i] = 1'b0;
            end
         end else begin
            bit tick, mtick, snz_p, stp_p;
            int nowm, budm, nxt;
            tick  = (int'(cnt_sec) != m_prev);
            mtick = tick && (cnt_sec == 6'd0);
            snz_p = h_snz[SYNC_STAGES-1] && !h_snz[SYNC_STAGES];
            stp_p = h_stp[SYNC_STAGES-1] && !h_stp[SYNC_STAGES];
            nowm  = to_min(hourdec_now, hourone_now, mindec_now, minone_now);
            budm  = to_min(hourdec_bud, hourone_bud, mindec_bud, minone_bud);
            if (!alarm_en) begin
               m_state = 0;
            end else if (m_state == 0) begin
               if (mtick && nowm >= 0 && nowm == budm) begin
                  m_state = 1; m_ring = 0;
               end
            end else if (m_state == 1) begin
               nxt = 1;
               if (stp_p) nxt = 0;
               else if (tick && m_ring == RING_SEC - 1) nxt = 0;
               else if (snz_p) begin
                  nxt = 2; m_snz = (nowm + SNOOZE_MIN) % 1440;
               end
               if (tick && m_ring < 63) m_ring++;
               m_state = nxt;
            end else begin
               if (stp_p) m_state = 0;
               else if (mtick && nowm >= 0 && (nowm == m_snz || nowm == budm)) begin
                  m_state = 1; m_ring = 0;
               end
            end
            m_prev = int'(cnt_sec);
            for (int i = SYNC_STAGES; i > 0; i--) begin
               h_snz[i] = h_snz[i-1]; h_stp[i] = h_stp[i-1];
            end
            h_snz[0] = snooze_btn; h_stp[0] = stop_btn;
         end
         check("model_aud_en",     int'(aud_en),     (m_state == 1) ? 1 : 0);
         check("model_snooze_act", int'(snooze_act), (m_state == 2) ? 1 : 0);
         check("model_ring_sec",   int'(ring_sec),   m_ring);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_sod(input int s);
      int h, m, sc;
      h = s / 3600; m = (s / 60) % 60; sc = s % 60;
      hourdec_now = 4'(h / 10); hourone_now = 4'(h % 10);
      mindec_now  = 4'(m / 10); minone_now  = 4'(m % 10);
      cnt_sec     = 6'(sc);
   endtask

   task automatic jump(input int h, input int m, input int s);
      sod = h * 3600 + m * 60 + s;
      drive_sod(sod);
      step(CPS);
   endtask

   task automatic advance(input int nsec);
      repeat (nsec) begin
         sod = (sod + 1) % 86400;
         drive_sod(sod);
         step(CPS);
      end
   endtask

   task automatic set_bud(input int h, input int m);
      hourdec_bud = 4'(h / 10); hourone_bud = 4'(h % 10);
      mindec_bud  = 4'(m / 10); minone_bud  = 4'(m % 10);
   endtask

   task automatic press(input bit snz, input bit stp);
      snooze_btn = snz; stop_btn = stp;
      step(4);
      snooze_btn = 1'b0; stop_btn = 1'b0;
      step(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit hit;
      rstn = 1'b1; alarm_en = 1'b1; snooze_btn = 1'b0; stop_btn = 1'b0;
      set_bud(7, 30);
      sod = 7 * 3600 + 29 * 60 + 59;
      drive_sod(sod);

      // 1: reset holds everything off, even across a matching minute
      step(3);
      check("rst_aud_en", int'(aud_en), 0);
      check("rst_snooze_act", int'(snooze_act), 0);
      check("rst_ring_sec", int'(ring_sec), 0);
      advance(1);
      check("rst_hold_match", int'(aud_en), 0);

      // Already 07:30 with seconds mid-minute: no ring
      jump(7, 30, 17);
      rstn = 1'b0;
      advance(3);
      check("mid_minute_no_ring", int'(aud_en), 0);

      // 2: match at the minute boundary, aud_en within 2 clocks
      jump(7, 29, 58);
      advance(1);
      sod = 7 * 3600 + 30 * 60;
      drive_sod(sod);
      hit = 1'b0;
      for (int i = 0; i < 2 && !hit; i++) begin
         @(negedge clk);
         if (aud_en) hit = 1'b1;
      end
      check("match_within_2clk", int'(hit), 1);
      check("match_ring_sec0", int'(ring_sec), 0);
      step(1);

      // 3: timeout after RING_SEC ticks
      advance(59);
      check("timeout_pre_aud", int'(aud_en), 1);
      check("timeout_pre_ring_sec", int'(ring_sec), 59);
      advance(1);
      check("timeout_aud_off", int'(aud_en), 0);
      advance(5);
      check("timeout_stays_off", int'(aud_en), 0);

      // 4: snooze across midnight 23:58 + 5 -> 00:03
      set_bud(23, 58);
      jump(23, 57, 59);
      advance(1);
      check("snz_ring_start", int'(aud_en), 1);
      press(1'b1, 1'b0);
      check("snz_act_on", int'(snooze_act), 1);
      check("snz_aud_off", int'(aud_en), 0);
      jump(0, 2, 58);
      advance(1);
      check("snz_wait_0259", int'(snooze_act), 1);
      advance(1);
      check("snz_expire_aud", int'(aud_en), 1);
      check("snz_expire_ring_sec", int'(ring_sec), 0);
      check("snz_expire_act_off", int'(snooze_act), 0);

      // 5: stop and snooze together -> idle; buttons ignored in idle
      press(1'b1, 1'b1);
      check("both_btn_aud", int'(aud_en), 0);
      check("both_btn_snz", int'(snooze_act), 0);
      press(1'b1, 1'b0);
      check("idle_btn_ignored", int'(snooze_act), 0);

      // alarm_en dropped while snoozing
      set_bud(0, 10);
      jump(0, 9, 59);
      advance(1);
      check("en_ring", int'(aud_en), 1);
      press(1'b1, 1'b0);
      check("en_snoozing", int'(snooze_act), 1);
      alarm_en = 1'b0;
      step(2);
      check("en_drop_snz", int'(snooze_act), 0);
      check("en_drop_aud", int'(aud_en), 0);
      alarm_en = 1'b1;
      advance(2);

      // 6: asynchronous reset mid-ring
      set_bud(12, 0);
      jump(11, 59, 59);
      advance(1);
      check("arst_ringing", int'(aud_en), 1);
      @(negedge clk);
      #2 rstn = 1'b1;
      #1 check("arst_immediate", int'(aud_en), 0);
      step(2);
      rstn = 1'b0;
      advance(5);
      check("arst_no_reringing", int'(aud_en), 0);
      jump(11, 59, 59);
      advance(1);
      check("arst_next_boundary", int'(aud_en), 1);
      press(1'b0, 1'b1);
      check("stop_in_ring", int'(aud_en), 0);

      // Non-BCD digits never match
      hourdec_bud = 4'd0; hourone_bud = 4'd7; mindec_bud = 4'd3; minone_bud = 4'hA;
      hourdec_now = 4'd0; hourone_now = 4'd7; mindec_now = 4'd3; minone_now = 4'hA;
      cnt_sec = 6'd59;
      step(CPS);
      cnt_sec = 6'd0;
      step(CPS);
      check("non_bcd_no_match", int'(aud_en), 0);

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
